// File: rtl/flow_vga_pkg.sv
// Shared types and default geometry for the VGA write arbiter.
package flow_vga_pkg;

   // Default framebuffer geometry and field widths.
   localparam int DEF_WIDTH      = 160;
   localparam int DEF_HEIGHT     = 120;
   localparam int DEF_X_BITS     = 8;
   localparam int DEF_Y_BITS     = 7;
   localparam int DEF_COLOR_BITS = 15;

   // Arbiter FSM: idle, or sweeping the whole framebuffer with one colour.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Which requester owns the write port this cycle.
   typedef enum logic [1:0] {
      GRANT_NONE  = 2'd0,
      GRANT_CPU   = 2'd1,
      GRANT_CLEAR = 2'd2
   } grant_t;

endpackage

// File: rtl/vga_clear_sweep.sv
// Raster-order x/y counter for the clear-screen sweep. x runs fastest;
// the counters move only when the sweep is granted the write port.
module vga_clear_sweep
   import flow_vga_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int X_BITS = DEF_X_BITS,
   parameter int Y_BITS = DEF_Y_BITS
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              restart,
   input  logic              advance,
   output logic [X_BITS-1:0] x,
   output logic [Y_BITS-1:0] y,
   output logic              last
);

   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

   // Final pixel of the frame; the arbiter ends the sweep when it grants this one.
   assign last = (x == X_LAST) && (y == Y_LAST);

   // Counter: zero on reset or a new sweep, step in raster order on each granted pixel.
   always_ff @(posedge clock) begin
      if (!resetn || restart) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA framebuffer write port between CPU plot requests and an
// internal clear-screen sweep. One pixel is written per cycle at most;
// when both requesters are pending they alternate round-robin.
//
// CPU handshake: a pixel is taken at a rising edge where cpu_valid and
// cpu_ready are both high. cpu_ready depends only on registered state
// (buffer occupancy and the grant computed from it), never on cpu_valid,
// and a full buffer that is being drained this cycle still accepts, so a
// continuous stream moves one pixel per cycle when uncontended.
module vga_write_arbiter
   import flow_vga_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int X_BITS     = DEF_X_BITS,
   parameter int Y_BITS     = DEF_Y_BITS,
   parameter int COLOR_BITS = DEF_COLOR_BITS
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  cpu_valid,
   input  logic [X_BITS-1:0]     cpu_x,
   input  logic [Y_BITS-1:0]     cpu_y,
   input  logic [COLOR_BITS-1:0] cpu_color,
   output logic                  cpu_ready,
   input  logic                  clear_start,
   input  logic [COLOR_BITS-1:0] clear_color,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic [X_BITS-1:0]     vga_x,
   output logic [Y_BITS-1:0]     vga_y,
   output logic [COLOR_BITS-1:0] vga_color,
   output logic                  vga_plot,
   output logic                  fsm_state
);

   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

   state_t                state, state_next;
   grant_t                grant, last_grant;

   logic                  buf_full;
   logic [X_BITS-1:0]     buf_x;
   logic [Y_BITS-1:0]     buf_y;
   logic [COLOR_BITS-1:0] buf_color;
   logic                  buf_in_range;
   logic                  cpu_accept;

   logic [COLOR_BITS-1:0] fill_color;
   logic                  sweep_restart;
   logic [X_BITS-1:0]     sweep_x;
   logic [Y_BITS-1:0]     sweep_y;
   logic                  sweep_last;

   // Out-of-range pixels still win arbitration but are never written.
   assign buf_in_range = (buf_x <= X_LAST) && (buf_y <= Y_LAST);

   assign cpu_ready  = !buf_full || (grant == GRANT_CPU);
   assign cpu_accept = cpu_valid && cpu_ready;
   assign clear_busy = (state == CLEAR);
   assign fsm_state  = (state == CLEAR);

   vga_clear_sweep #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_sweep (
      .clock   (clock),
      .resetn  (resetn),
      .restart (sweep_restart),
      .advance (grant == GRANT_CLEAR),
      .x       (sweep_x),
      .y       (sweep_y),
      .last    (sweep_last)
   );

   // Round-robin grant: a lone requester always wins; under contention the
   // one not granted last time wins.
   always_comb begin
      grant = GRANT_NONE;
      if (buf_full && (state == CLEAR)) begin
         grant = (last_grant == GRANT_CPU) ? GRANT_CLEAR : GRANT_CPU;
      end else if (buf_full) begin
         grant = GRANT_CPU;
      end else if (state == CLEAR) begin
         grant = GRANT_CLEAR;
      end
   end

   // Next state: start a sweep from idle, finish when the last pixel is granted.
   always_comb begin
      state_next    = state;
      sweep_restart = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear_start) begin
               state_next    = CLEAR;
               sweep_restart = 1'b1;
            end
         end
         CLEAR: begin
            if ((grant == GRANT_CLEAR) && sweep_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus the fill colour captured when a sweep starts.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= IDLE;
         fill_color <= '0;
      end else begin
         state <= state_next;
         if (sweep_restart) begin
            fill_color <= clear_color;
         end
      end
   end

   // Round-robin history; reset to CLEAR so the first contention favours the CPU.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         last_grant <= GRANT_CLEAR;
      end else if (grant != GRANT_NONE) begin
         last_grant <= grant;
      end
   end

   // One-deep CPU holding buffer; a load in the draining cycle keeps it full.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         buf_full  <= 1'b0;
         buf_x     <= '0;
         buf_y     <= '0;
         buf_color <= '0;
      end else if (cpu_accept) begin
         buf_full  <= 1'b1;
         buf_x     <= cpu_x;
         buf_y     <= cpu_y;
         buf_color <= cpu_color;
      end else if (grant == GRANT_CPU) begin
         buf_full  <= 1'b0;
      end
   end

   // Registered write port: strobe on each written pixel, coordinates hold otherwise.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         vga_plot   <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_color  <= '0;
         clear_done <= 1'b0;
      end else begin
         vga_plot   <= 1'b0;
         clear_done <= 1'b0;
         unique case (grant)
            GRANT_CPU: begin
               if (buf_in_range) begin
                  vga_plot  <= 1'b1;
                  vga_x     <= buf_x;
                  vga_y     <= buf_y;
                  vga_color <= buf_color;
               end
            end
            GRANT_CLEAR: begin
               vga_plot   <= 1'b1;
               vga_x      <= sweep_x;
               vga_y      <= sweep_y;
               vga_color  <= fill_color;
               clear_done <= sweep_last;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: a default 160x120 instance and a
// 4x2 instance for short clear sweeps.
module tb_vga_write_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   // Default-geometry instance
   logic        d_resetn, d_valid, d_cstart;
   logic [7:0]  d_cx;
   logic [6:0]  d_cy;
   logic [14:0] d_ccol, d_fill;
   logic        d_ready, d_busy, d_done, d_plot, d_state;
   logic [7:0]  d_x;
   logic [6:0]  d_y;
   logic [14:0] d_color;

   // 4x2 instance
   logic        s_resetn, s_valid, s_cstart;
   logic [7:0]  s_cx;
   logic [6:0]  s_cy;
   logic [14:0] s_ccol, s_fill;
   logic        s_ready, s_busy, s_done, s_plot, s_state;
   logic [7:0]  s_x;
   logic [6:0]  s_y;
   logic [14:0] s_color;

   vga_write_arbiter dut (
      .clock (clock), .resetn (d_resetn),
      .cpu_valid (d_valid), .cpu_x (d_cx), .cpu_y (d_cy), .cpu_color (d_ccol),
      .cpu_ready (d_ready), .clear_start (d_cstart), .clear_color (d_fill),
      .clear_busy (d_busy), .clear_done (d_done),
      .vga_x (d_x), .vga_y (d_y), .vga_color (d_color), .vga_plot (d_plot),
      .fsm_state (d_state)
   );

   vga_write_arbiter #(.WIDTH(4), .HEIGHT(2)) dut_s (
      .clock (clock), .resetn (s_resetn),
      .cpu_valid (s_valid), .cpu_x (s_cx), .cpu_y (s_cy), .cpu_color (s_ccol),
      .cpu_ready (s_ready), .clear_start (s_cstart), .clear_color (s_fill),
      .clear_busy (s_busy), .clear_done (s_done),
      .vga_x (s_x), .vga_y (s_y), .vga_color (s_color), .vga_plot (s_plot),
      .fsm_state (s_state)
   );

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      d_resetn = 0; d_valid = 0; d_cstart = 0; d_cx = 0; d_cy = 0; d_ccol = 0; d_fill = 0;
      s_resetn = 0; s_valid = 0; s_cstart = 0; s_cx = 0; s_cy = 0; s_ccol = 0; s_fill = 0;
      tick();
      tick();
      n_total++;
      if ({d_plot, d_x, d_y, d_color, d_busy, d_done, d_ready, d_state} !==
          {1'b0, 8'd0, 7'd0, 15'd0, 1'b0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset_default: got %h exp %h",
                  {d_plot, d_x, d_y, d_color, d_busy, d_done, d_ready, d_state},
                  {1'b0, 8'd0, 7'd0, 15'd0, 1'b0, 1'b0, 1'b1, 1'b0});
      else n_pass++;
      n_total++;
      if ({s_plot, s_x, s_y, s_color, s_busy, s_done, s_ready, s_state} !==
          {1'b0, 8'd0, 7'd0, 15'd0, 1'b0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset_small: got %h exp %h",
                  {s_plot, s_x, s_y, s_color, s_busy, s_done, s_ready, s_state},
                  {1'b0, 8'd0, 7'd0, 15'd0, 1'b0, 1'b0, 1'b1, 1'b0});
      else n_pass++;
      d_resetn = 1;
      s_resetn = 1;
      tick();
      n_total++;
      if ({d_plot, d_busy, s_plot, s_busy} !== 4'b0000)
         $display("FAIL reset_release: got %b exp 0000", {d_plot, d_busy, s_plot, s_busy});
      else n_pass++;
   endtask

   task automatic test_single();
      d_valid = 1; d_cx = 8'd5; d_cy = 7'd7; d_ccol = 15'h7C00;
      n_total++;
      if (d_ready !== 1'b1) $display("FAIL single_ready: got %b exp 1", d_ready);
      else n_pass++;
      tick();
      d_valid = 0;
      n_total++;
      if (d_plot !== 1'b0) $display("FAIL single_latency: plot got %b exp 0", d_plot);
      else n_pass++;
      tick();
      n_total++;
      if ({d_plot, d_x, d_y, d_color} !== {1'b1, 8'd5, 7'd7, 15'h7C00})
         $display("FAIL single_plot: got %h exp %h", {d_plot, d_x, d_y, d_color},
                  {1'b1, 8'd5, 7'd7, 15'h7C00});
      else n_pass++;
      tick();
      n_total++;
      if ({d_plot, d_x, d_y, d_color} !== {1'b0, 8'd5, 7'd7, 15'h7C00})
         $display("FAIL single_once: got %h exp %h", {d_plot, d_x, d_y, d_color},
                  {1'b0, 8'd5, 7'd7, 15'h7C00});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            d_valid = 1; d_cx = 8'(i); d_cy = 7'd0; d_ccol = 15'(15'h1000 + i);
            n_total++;
            if (d_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b exp 1", i, d_ready);
            else n_pass++;
         end else begin
            d_valid = 0;
         end
         tick();
         n_total++;
         if (i == 0) begin
            if (d_plot !== 1'b0) $display("FAIL b2b_first: plot got %b exp 0", d_plot);
            else n_pass++;
         end else begin
            if ({d_plot, d_x, d_y, d_color} !== {1'b1, 8'(i - 1), 7'd0, 15'(15'h1000 + i - 1)})
               $display("FAIL b2b_plot[%0d]: got %h exp %h", i, {d_plot, d_x, d_y, d_color},
                        {1'b1, 8'(i - 1), 7'd0, 15'(15'h1000 + i - 1)});
            else n_pass++;
         end
      end
      tick();
      n_total++;
      if ({d_plot, d_x, d_color} !== {1'b0, 8'd3, 15'h1003})
         $display("FAIL b2b_end: got %h exp %h", {d_plot, d_x, d_color}, {1'b0, 8'd3, 15'h1003});
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      // x just past the right edge
      d_valid = 1; d_cx = 8'd160; d_cy = 7'd0; d_ccol = 15'h7FFF;
      n_total++;
      if (d_ready !== 1'b1) $display("FAIL oor_ready: got %b exp 1", d_ready);
      else n_pass++;
      tick();
      d_valid = 0;
      tick();
      n_total++;
      if ({d_plot, d_x, d_y, d_color, d_ready} !== {1'b0, 8'd3, 7'd0, 15'h1003, 1'b1})
         $display("FAIL oor_x_no_plot: got %h exp %h", {d_plot, d_x, d_y, d_color, d_ready},
                  {1'b0, 8'd3, 7'd0, 15'h1003, 1'b1});
      else n_pass++;
      // y just past the bottom edge
      d_valid = 1; d_cx = 8'd10; d_cy = 7'd120; d_ccol = 15'h7FFF;
      tick();
      d_valid = 0;
      tick();
      n_total++;
      if ({d_plot, d_x, d_y, d_color} !== {1'b0, 8'd3, 7'd0, 15'h1003})
         $display("FAIL oor_y_no_plot: got %h exp %h", {d_plot, d_x, d_y, d_color},
                  {1'b0, 8'd3, 7'd0, 15'h1003});
      else n_pass++;
      // corner pixel (159,119) is in range
      d_valid = 1; d_cx = 8'd159; d_cy = 7'd119; d_ccol = 15'h0123;
      tick();
      d_valid = 0;
      tick();
      n_total++;
      if ({d_plot, d_x, d_y, d_color} !== {1'b1, 8'd159, 7'd119, 15'h0123})
         $display("FAIL corner_plot: got %h exp %h", {d_plot, d_x, d_y, d_color},
                  {1'b1, 8'd159, 7'd119, 15'h0123});
      else n_pass++;
      tick();
   endtask

   task automatic test_clear_sweep();
      s_fill = 15'h001F; s_cstart = 1;
      tick();
      s_cstart = 0; s_fill = 15'h0000;
      n_total++;
      if ({s_busy, s_plot, s_state} !== 3'b101)
         $display("FAIL sweep_start: got %b exp 101", {s_busy, s_plot, s_state});
      else n_pass++;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_total++;
         if ({s_plot, s_x, s_y, s_color, s_done, s_busy} !==
             {1'b1, 8'(k % 4), 7'(k / 4), 15'h001F, (k == 7), (k < 7)})
            $display("FAIL sweep_pixel[%0d]: got %h exp %h", k,
                     {s_plot, s_x, s_y, s_color, s_done, s_busy},
                     {1'b1, 8'(k % 4), 7'(k / 4), 15'h001F, (k == 7), (k < 7)});
         else n_pass++;
      end
      tick();
      n_total++;
      if ({s_plot, s_done, s_busy} !== 3'b000)
         $display("FAIL sweep_after: got %b exp 000", {s_plot, s_done, s_busy});
      else n_pass++;
   endtask

   task automatic test_contention();
      s_resetn = 0;
      tick();
      s_resetn = 1;
      s_valid = 1; s_cx = 8'd1; s_cy = 7'd1; s_ccol = 15'h03E0;
      s_cstart = 1; s_fill = 15'h001F;
      n_total++;
      if (s_ready !== 1'b1) $display("FAIL cont_first_ready: got %b exp 1", s_ready);
      else n_pass++;
      tick();
      s_cstart = 0;
      for (int k = 0; k < 16; k++) begin
         n_total++;
         if (s_ready !== (k % 2 == 0))
            $display("FAIL cont_ready[%0d]: got %b exp %b", k, s_ready, (k % 2 == 0));
         else n_pass++;
         tick();
         n_total++;
         if (k % 2 == 0) begin
            if ({s_plot, s_x, s_y, s_color, s_done} !== {1'b1, 8'd1, 7'd1, 15'h03E0, 1'b0})
               $display("FAIL cont_cpu[%0d]: got %h exp %h", k, {s_plot, s_x, s_y, s_color, s_done},
                        {1'b1, 8'd1, 7'd1, 15'h03E0, 1'b0});
            else n_pass++;
         end else begin
            if ({s_plot, s_x, s_y, s_color, s_done} !==
                {1'b1, 8'((k / 2) % 4), 7'((k / 2) / 4), 15'h001F, (k == 15)})
               $display("FAIL cont_clear[%0d]: got %h exp %h", k,
                        {s_plot, s_x, s_y, s_color, s_done},
                        {1'b1, 8'((k / 2) % 4), 7'((k / 2) / 4), 15'h001F, (k == 15)});
            else n_pass++;
         end
      end
      s_valid = 0;
      n_total++;
      if (s_busy !== 1'b0) $display("FAIL cont_busy_end: got %b exp 0", s_busy);
      else n_pass++;
      tick();
      n_total++;
      if ({s_plot, s_x, s_y, s_color} !== {1'b1, 8'd1, 7'd1, 15'h03E0})
         $display("FAIL cont_drain: got %h exp %h", {s_plot, s_x, s_y, s_color},
                  {1'b1, 8'd1, 7'd1, 15'h03E0});
      else n_pass++;
      tick();
      n_total++;
      if (s_plot !== 1'b0) $display("FAIL cont_idle: plot got %b exp 0", s_plot);
      else n_pass++;
   endtask

   task automatic test_reset_mid_sweep();
      d_fill = 15'h0ABC; d_cstart = 1;
      tick();
      d_cstart = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_total++;
         if ({d_plot, d_x, d_y, d_color} !== {1'b1, 8'(k), 7'd0, 15'h0ABC})
            $display("FAIL mid_pixel[%0d]: got %h exp %h", k, {d_plot, d_x, d_y, d_color},
                     {1'b1, 8'(k), 7'd0, 15'h0ABC});
         else n_pass++;
      end
      d_cstart = 1;
      tick();
      d_cstart = 0;
      n_total++;
      if ({d_plot, d_x, d_y, d_busy} !== {1'b1, 8'd3, 7'd0, 1'b1})
         $display("FAIL mid_start_ignored: got %h exp %h", {d_plot, d_x, d_y, d_busy},
                  {1'b1, 8'd3, 7'd0, 1'b1});
      else n_pass++;
      d_valid = 1; d_cx = 8'd20; d_cy = 7'd20; d_ccol = 15'h5555;
      n_total++;
      if (d_ready !== 1'b1) $display("FAIL mid_cpu_ready: got %b exp 1", d_ready);
      else n_pass++;
      tick();
      d_valid = 0;
      d_resetn = 0;
      tick();
      n_total++;
      if ({d_plot, d_busy, d_state, d_ready, d_done, d_x, d_y, d_color} !==
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 7'd0, 15'd0})
         $display("FAIL mid_reset: got %h exp %h",
                  {d_plot, d_busy, d_state, d_ready, d_done, d_x, d_y, d_color},
                  {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 7'd0, 15'd0});
      else n_pass++;
      d_resetn = 1;
      tick();
      tick();
      n_total++;
      if ({d_plot, d_busy, d_x} !== {1'b0, 1'b0, 8'd0})
         $display("FAIL mid_buffer_discarded: got %h exp %h", {d_plot, d_busy, d_x},
                  {1'b0, 1'b0, 8'd0});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_out_of_range();
      test_clear_sweep();
      test_contention();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
